sumador_bandas_sat: RTL

- Parametrised N-band output summer for the equalizer datapath. Sits after the band filters (low/mid/high, extendable) and ahead of the DAC interface.
- Applies a per-band signed gain to each band sample and accumulates the bands serially, one per clock. The sum is saturated to the DAC width and converted to offset-binary.
- Adds a valid/ready input handshake, an output valid pulse, and sticky overflow/underflow flags.

---
 rtl/sumador_bandas_sat.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sumador_bandas_sat.sv
`default_nettype none
// ============================================================================
// Module      : sumador_bandas_sat
// Description : N-band output summer for the equalizer datapath. A band
//               vector and its gain vector are captured on a valid/ready
//               handshake. Each band is weighted by its signed gain, one band
//               per clock. The sum is saturated to the DAC width and emitted
//               as offset-binary. Sticky flags record when the output clipped.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   CLK        in   1      system clock, rising edge
//   Reset      in   1      asynchronous reset, active low
//   in_valid   in   1      band vector valid
//   in_ready   out  1      block can accept a band vector (IDLE only)
//   y_bandas   in   N*W    packed signed band samples, band i = [i*W +: W]
//   ganancias  in   N*GW   packed signed Q2.(GW-2) gains, gain i = [i*GW +: GW]
//   clr_flags  in   1      synchronous clear of sat_pos / sat_neg
//   ys         out  WO     offset-binary output sample, held between results
//   out_valid  out  1      one-cycle pulse, ys is new this cycle
//   sat_pos    out  1      sticky: positive saturation occurred
//   sat_neg    out  1      sticky: negative saturation occurred
// ============================================================================
module sumador_bandas_sat #(
  parameter int N  = 3,
  parameter int W  = 23,
  parameter int GW = 8,
  parameter int WO = 12
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*W-1:0]    y_bandas,
  input  logic [N*GW-1:0]   ganancias,
  input  logic              clr_flags,
  output logic [WO-1:0]     ys,
  output logic              out_valid,
  output logic              sat_pos,
  output logic              sat_neg
);

  // Accumulator is wide enough that N full-scale weighted bands never wrap.
  localparam int IW = $clog2(N);
  localparam int AW = W + GW + IW;

  // Saturation limits of the DAC range, expressed at accumulator width.
  localparam logic signed [AW-1:0] C_MAX = {{(AW-WO+1){1'b0}}, {(WO-1){1'b1}}};
  localparam logic signed [AW-1:0] C_MIN = ~C_MAX;
  localparam logic [WO-1:0]        C_MID = {1'b1, {(WO-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACUM = 2'd1,
    SAT  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;

  logic [N*W-1:0]          r_x;
  logic [N*GW-1:0]         r_g;
  logic signed [AW-1:0]    r_acc;
  logic [IW-1:0]           r_idx;
  logic [WO-1:0]           r_ys;
  logic                    r_out_valid;
  logic                    r_sat_pos;
  logic                    r_sat_neg;

  logic signed [W-1:0]     w_x;
  logic signed [GW-1:0]    w_g;
  logic signed [W+GW-1:0]  w_prod;
  logic signed [AW-1:0]    w_prod_ext;
  logic signed [AW-1:0]    w_term;
  logic                    w_over;
  logic                    w_under;
  logic                    w_last;
  logic [WO-1:0]           w_sat;

  // --------------------------------------------------------------------------
  // Weighted band term for the current index
  // --------------------------------------------------------------------------
  assign w_x        = r_x[r_idx*W +: W];
  assign w_g        = r_g[r_idx*GW +: GW];
  assign w_prod     = w_x * w_g;
  assign w_prod_ext = {{IW{w_prod[W+GW-1]}}, w_prod};
  // Arithmetic shift removes the gain's fractional bits, flooring toward -inf.
  assign w_term     = w_prod_ext >>> (GW - 2);
  assign w_last     = (r_idx == IW'(N - 1));

  // --------------------------------------------------------------------------
  // Saturation to the DAC range
  // --------------------------------------------------------------------------
  assign w_over  = (r_acc > C_MAX);
  assign w_under = (r_acc < C_MIN);

  always_comb begin
    w_sat = r_acc[WO-1:0];
    if (w_over) begin
      w_sat = C_MAX[WO-1:0];
    end else if (w_under) begin
      w_sat = C_MIN[WO-1:0];
    end
  end

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = ACUM;
      ACUM:    if (w_last)   w_next = SAT;
      SAT:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and flags
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_x         <= '0;
      r_g         <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_ys        <= C_MID;
      r_out_valid <= 1'b0;
      r_sat_pos   <= 1'b0;
      r_sat_neg   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x   <= y_bandas;
            r_g   <= ganancias;
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        ACUM: begin
          r_acc <= r_acc + w_term;
          r_idx <= r_idx + IW'(1);
        end
        SAT: begin
          // Adding mid-scale to a WO-bit two's-complement value is the same
          // as inverting its sign bit.
          r_ys        <= {~w_sat[WO-1], w_sat[WO-2:0]};
          r_out_valid <= 1'b1;
        end
        default: ;
      endcase
      // A saturation event on the same edge as a clear keeps the flag set.
      r_sat_pos <= ((r_state == SAT) && w_over)  | (r_sat_pos & ~clr_flags);
      r_sat_neg <= ((r_state == SAT) && w_under) | (r_sat_neg & ~clr_flags);
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign ys        = r_ys;
  assign out_valid = r_out_valid;
  assign sat_pos   = r_sat_pos;
  assign sat_neg   = r_sat_neg;

endmodule
`default_nettype wire
